// File: rtl/sad_min_tracker.sv
// sad_min_tracker
// Tracks the minimum SAD and the motion vector that produced it, separately for
// every partition lane, across one integer motion-estimation search window.
// A window is opened by start, fed one candidate per cycle, closed by the
// candidate flagged sad_last, and the results are held until downstream takes
// them through the out_valid/out_ready handshake.

module sad_min_tracker #(
  parameter int NUM_CH = 32,
  parameter int SAD_W  = 13,
  parameter int MV_W   = 7,
  parameter int CNT_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sad_valid,
  input  logic                    sad_last,
  input  logic [NUM_CH*SAD_W-1:0] sad_in,
  input  logic [MV_W-1:0]         mv_x,
  input  logic [MV_W-1:0]         mv_y,
  output logic [NUM_CH*SAD_W-1:0] min_sad,
  output logic [NUM_CH*MV_W-1:0]  min_mv_x,
  output logic [NUM_CH*MV_W-1:0]  min_mv_y,
  output logic [CNT_W-1:0]        cand_cnt,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The all-ones SAD doubles as the "nothing better seen yet" sentinel, so a
  // lane that never sees a smaller value reports it unchanged with MV 0.
  localparam logic [SAD_W-1:0] SAD_INIT = {SAD_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t state_q;
  state_t state_d;

  // init_win reinitialises every accumulator; accept folds one candidate in.
  // They are mutually exclusive: a start in SEARCH drops any coincident sample.
  logic init_win;
  logic accept;

  logic [SAD_W-1:0] min_sad_q  [NUM_CH];
  logic [MV_W-1:0]  min_mv_x_q [NUM_CH];
  logic [MV_W-1:0]  min_mv_y_q [NUM_CH];
  logic [SAD_W-1:0] lane_sad   [NUM_CH];
  logic             lane_better[NUM_CH];

  // Next-state and window control; start is only honoured outside DONE so a
  // finished result cannot be clobbered before downstream has consumed it.
  always_comb begin
    state_d  = state_q;
    init_win = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          init_win = 1'b1;
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
        if (start) begin
          init_win = 1'b1;
        end else if (sad_valid) begin
          accept = 1'b1;
          if (sad_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset always returns to IDLE regardless of activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status flags decode straight from the state so they change on the same
  // edge that moves the FSM.
  always_comb begin
    busy      = (state_q == SEARCH);
    out_valid = (state_q == DONE);
  end

  // Candidate counter saturates rather than wrapping so a long window never
  // appears to have seen fewer candidates than a short one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_cnt <= '0;
    end else if (init_win) begin
      cand_cnt <= '0;
    end else if (accept && (cand_cnt != CNT_MAX)) begin
      cand_cnt <= cand_cnt + CNT_W'(1);
    end
  end

  // Split the packed SAD bus into lanes and decide per lane whether the new
  // candidate strictly beats the held minimum; ties keep the earlier winner.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lane_sad[c]    = sad_in[c*SAD_W +: SAD_W];
      lane_better[c] = (lane_sad[c] < min_sad_q[c]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      // Per-lane minimum and its motion vector; lanes update independently.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          min_sad_q[g]  <= SAD_INIT;
          min_mv_x_q[g] <= '0;
          min_mv_y_q[g] <= '0;
        end else if (init_win) begin
          min_sad_q[g]  <= SAD_INIT;
          min_mv_x_q[g] <= '0;
          min_mv_y_q[g] <= '0;
        end else if (accept && lane_better[g]) begin
          min_sad_q[g]  <= lane_sad[g];
          min_mv_x_q[g] <= mv_x;
          min_mv_y_q[g] <= mv_y;
        end
      end
    end
  endgenerate

  // Repack the per-lane registers onto the flat output buses.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      min_sad[c*SAD_W +: SAD_W] = min_sad_q[c];
      min_mv_x[c*MV_W +: MV_W]  = min_mv_x_q[c];
      min_mv_y[c*MV_W +: MV_W]  = min_mv_y_q[c];
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed testbench for sad_min_tracker. A default-parameter instance carries
// the functional scenarios; a second instance with CNT_W=3 shares the same
// stimulus so counter saturation can be observed.

module tb_sad_min_tracker;

  localparam int NUM_CH = 32;
  localparam int SAD_W  = 13;
  localparam int MV_W   = 7;
  localparam int CNT_W  = 12;
  localparam int CNT_W2 = 3;

  localparam logic [SAD_W-1:0]        ONES    = {SAD_W{1'b1}};
  localparam logic [NUM_CH*SAD_W-1:0] ALL_ONE = {(NUM_CH*SAD_W){1'b1}};

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    sad_valid;
  logic                    sad_last;
  logic [NUM_CH*SAD_W-1:0] sad_in;
  logic [MV_W-1:0]         mv_x;
  logic [MV_W-1:0]         mv_y;
  logic                    out_ready;

  logic [NUM_CH*SAD_W-1:0] min_sad;
  logic [NUM_CH*MV_W-1:0]  min_mv_x;
  logic [NUM_CH*MV_W-1:0]  min_mv_y;
  logic [CNT_W-1:0]        cand_cnt;
  logic                    busy;
  logic                    out_valid;

  logic [NUM_CH*SAD_W-1:0] min_sad2;
  logic [NUM_CH*MV_W-1:0]  min_mv_x2;
  logic [NUM_CH*MV_W-1:0]  min_mv_y2;
  logic [CNT_W2-1:0]       cand_cnt2;
  logic                    busy2;
  logic                    out_valid2;

  int n_cmp;
  int n_fail;

  sad_min_tracker #(.NUM_CH(NUM_CH), .SAD_W(SAD_W), .MV_W(MV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sad_valid(sad_valid), .sad_last(sad_last),
    .sad_in(sad_in), .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad), .min_mv_x(min_mv_x),
    .min_mv_y(min_mv_y), .cand_cnt(cand_cnt), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  sad_min_tracker #(.NUM_CH(NUM_CH), .SAD_W(SAD_W), .MV_W(MV_W), .CNT_W(CNT_W2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .sad_valid(sad_valid), .sad_last(sad_last),
    .sad_in(sad_in), .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad2), .min_mv_x(min_mv_x2),
    .min_mv_y(min_mv_y2), .cand_cnt(cand_cnt2), .busy(busy2), .out_valid(out_valid2),
    .out_ready(out_ready)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one candidate: lanes 0 and 1 get the given SADs, all other lanes
  // get the all-ones sentinel.
  task automatic drive_cand(input logic [SAD_W-1:0] s0, input logic [SAD_W-1:0] s1,
                            input int x, input int y, input logic last);
    sad_in              = ALL_ONE;
    sad_in[0 +: SAD_W]     = s0;
    sad_in[SAD_W +: SAD_W] = s1;
    mv_x      = MV_W'(x);
    mv_y      = MV_W'(y);
    sad_valid = 1'b1;
    sad_last  = last;
  endtask

  task automatic idle_inputs();
    sad_valid = 1'b0;
    sad_last  = 1'b0;
    start     = 1'b0;
    sad_in    = ALL_ONE;
    mv_x      = '0;
    mv_y      = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (min_sad !== ALL_ONE) begin n_fail++; $display("[TB] FAIL reset_min_sad got %h want all ones", min_sad); end
    n_cmp++; if (min_mv_x !== '0) begin n_fail++; $display("[TB] FAIL reset_mv_x got %h want 0", min_mv_x); end
    n_cmp++; if (min_mv_y !== '0) begin n_fail++; $display("[TB] FAIL reset_mv_y got %h want 0", min_mv_y); end
    n_cmp++; if (cand_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_cnt got %0d want 0", cand_cnt); end
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags got busy=%b ov=%b want 0 0", busy, out_valid); end
    rst_n = 1'b1;
    step();
    drive_cand(13'd5, 13'd5, 1, 1, 1'b1);
    step();
    idle_inputs();
    n_cmp++; if (min_sad[0 +: SAD_W] !== ONES) begin n_fail++; $display("[TB] FAIL idle_ignore_sad got %0d want 8191", min_sad[0 +: SAD_W]); end
    n_cmp++; if (cand_cnt !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ignore_state got cnt=%0d busy=%b ov=%b want 0 0 0", cand_cnt, busy, out_valid); end
  endtask

  task automatic test_search();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL search_enter got busy=%b ov=%b want 1 0", busy, out_valid); end
    drive_cand(13'd100, ONES, 1, 2, 1'b0);
    step();
    n_cmp++; if (min_sad[0 +: SAD_W] !== 13'd100) begin n_fail++; $display("[TB] FAIL search_first got %0d want 100", min_sad[0 +: SAD_W]); end
    drive_cand(13'd40, ONES, -3, 4, 1'b0);
    step();
    drive_cand(13'd70, ONES, 5, -6, 1'b1);
    step();
    idle_inputs();
    n_cmp++; if (min_sad[0 +: SAD_W] !== 13'd40) begin n_fail++; $display("[TB] FAIL search_min got %0d want 40", min_sad[0 +: SAD_W]); end
    n_cmp++; if (min_mv_x[0 +: MV_W] !== MV_W'(-3) || min_mv_y[0 +: MV_W] !== MV_W'(4)) begin n_fail++; $display("[TB] FAIL search_mv got (%h,%h) want (7d,04)", min_mv_x[0 +: MV_W], min_mv_y[0 +: MV_W]); end
    n_cmp++; if (cand_cnt !== 12'd3) begin n_fail++; $display("[TB] FAIL search_cnt got %0d want 3", cand_cnt); end
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL search_done got ov=%b busy=%b want 1 0", out_valid, busy); end
    n_cmp++; if (min_sad[2*SAD_W +: SAD_W] !== ONES || min_mv_x[2*MV_W +: MV_W] !== '0 || min_mv_y[2*MV_W +: MV_W] !== '0) begin n_fail++; $display("[TB] FAIL search_sentinel got sad=%0d mv=(%h,%h) want 8191 (0,0)", min_sad[2*SAD_W +: SAD_W], min_mv_x[2*MV_W +: MV_W], min_mv_y[2*MV_W +: MV_W]); end
  endtask

  task automatic test_handshake();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cand(13'd1, 13'd1, 7, 7, 1'b1);
      start = 1'b1;
      step();
      n_cmp++; if (min_sad[0 +: SAD_W] !== 13'd40 || cand_cnt !== 12'd3 || out_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_frozen cycle %0d got sad=%0d cnt=%0d ov=%b busy=%b want 40 3 1 0", i, min_sad[0 +: SAD_W], cand_cnt, out_valid, busy); end
    end
    idle_inputs();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL handshake_idle got ov=%b busy=%b want 0 0", out_valid, busy); end
    n_cmp++; if (min_sad[0 +: SAD_W] !== 13'd40 || min_mv_x[0 +: MV_W] !== MV_W'(-3)) begin n_fail++; $display("[TB] FAIL handshake_keep got sad=%0d mvx=%h want 40 7d", min_sad[0 +: SAD_W], min_mv_x[0 +: MV_W]); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || min_sad[0 +: SAD_W] !== ONES || cand_cnt !== '0) begin n_fail++; $display("[TB] FAIL restart got busy=%b sad=%0d cnt=%0d want 1 8191 0", busy, min_sad[0 +: SAD_W], cand_cnt); end
  endtask

  task automatic test_tie();
    drive_cand(ONES, 13'd50, 2, 2, 1'b0);
    step();
    drive_cand(ONES, 13'd50, -1, -1, 1'b1);
    step();
    idle_inputs();
    n_cmp++; if (min_sad[SAD_W +: SAD_W] !== 13'd50) begin n_fail++; $display("[TB] FAIL tie_sad got %0d want 50", min_sad[SAD_W +: SAD_W]); end
    n_cmp++; if (min_mv_x[MV_W +: MV_W] !== MV_W'(2) || min_mv_y[MV_W +: MV_W] !== MV_W'(2)) begin n_fail++; $display("[TB] FAIL tie_mv got (%h,%h) want (02,02)", min_mv_x[MV_W +: MV_W], min_mv_y[MV_W +: MV_W]); end
    n_cmp++; if (min_sad[0 +: SAD_W] !== ONES || min_mv_x[0 +: MV_W] !== '0 || min_mv_y[0 +: MV_W] !== '0) begin n_fail++; $display("[TB] FAIL tie_allones got sad=%0d mv=(%h,%h) want 8191 (0,0)", min_sad[0 +: SAD_W], min_mv_x[0 +: MV_W], min_mv_y[0 +: MV_W]); end
    n_cmp++; if (cand_cnt !== 12'd2 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL tie_done got cnt=%0d ov=%b want 2 1", cand_cnt, out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    drive_cand(13'd10, ONES, 1, 1, 1'b0);
    step();
    drive_cand(13'd20, ONES, 2, 2, 1'b0);
    step();
    idle_inputs();
    n_cmp++; if (min_sad[0 +: SAD_W] !== 13'd10 || cand_cnt !== 12'd2) begin n_fail++; $display("[TB] FAIL abort_pre got sad=%0d cnt=%0d want 10 2", min_sad[0 +: SAD_W], cand_cnt); end
    drive_cand(13'd3, ONES, 3, 3, 1'b1);
    start = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (min_sad[0 +: SAD_W] !== ONES || min_mv_x[0 +: MV_W] !== '0 || cand_cnt !== '0) begin n_fail++; $display("[TB] FAIL abort_clear got sad=%0d mvx=%h cnt=%0d want 8191 0 0", min_sad[0 +: SAD_W], min_mv_x[0 +: MV_W], cand_cnt); end
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_state got busy=%b ov=%b want 1 0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_cand(SAD_W'(9 - i), ONES, i + 1, -(i + 1), (i == 3));
      step();
      n_cmp++; if (min_sad[0 +: SAD_W] !== SAD_W'(9 - i) || cand_cnt !== CNT_W'(i + 1)) begin n_fail++; $display("[TB] FAIL b2b_step %0d got sad=%0d cnt=%0d want %0d %0d", i, min_sad[0 +: SAD_W], cand_cnt, 9 - i, i + 1); end
    end
    idle_inputs();
    n_cmp++; if (min_mv_x[0 +: MV_W] !== MV_W'(4) || min_mv_y[0 +: MV_W] !== MV_W'(-4) || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_final got mv=(%h,%h) ov=%b want (04,7c) 1", min_mv_x[0 +: MV_W], min_mv_y[0 +: MV_W], out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_saturation_and_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cand(SAD_W'(200 - 10 * i), ONES, i, -i, 1'b0);
      step();
    end
    idle_inputs();
    n_cmp++; if (cand_cnt2 !== 3'd7) begin n_fail++; $display("[TB] FAIL sat_cnt got %0d want 7", cand_cnt2); end
    n_cmp++; if (cand_cnt !== 12'd10) begin n_fail++; $display("[TB] FAIL wide_cnt got %0d want 10", cand_cnt); end
    n_cmp++; if (min_sad[0 +: SAD_W] !== 13'd110 || min_mv_x[0 +: MV_W] !== MV_W'(9) || min_mv_y[0 +: MV_W] !== MV_W'(-9)) begin n_fail++; $display("[TB] FAIL sat_min got sad=%0d mv=(%h,%h) want 110 (09,77)", min_sad[0 +: SAD_W], min_mv_x[0 +: MV_W], min_mv_y[0 +: MV_W]); end
    n_cmp++; if (busy !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_busy got %b %b want 1 1", busy, busy2); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (min_sad !== ALL_ONE || min_mv_x !== '0 || min_mv_y !== '0) begin n_fail++; $display("[TB] FAIL async_reset_lanes got sad0=%0d mvx0=%h want 8191 0", min_sad[0 +: SAD_W], min_mv_x[0 +: MV_W]); end
    n_cmp++; if (cand_cnt !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_state got cnt=%0d busy=%b ov=%b want 0 0 0", cand_cnt, busy, out_valid); end
    n_cmp++; if (cand_cnt2 !== '0 || busy2 !== 1'b0 || min_sad2 !== ALL_ONE) begin n_fail++; $display("[TB] FAIL async_reset_sat got cnt=%0d busy=%b want 0 0", cand_cnt2, busy2); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    idle_inputs();
    test_reset();
    test_search();
    test_handshake();
    test_tie();
    test_abort();
    test_back_to_back();
    test_saturation_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
